multi_channel_tick_timer: RTL and testbench

- Parametrised successor to the single fixed 1 ms tick generator.
- Shared prescaler derives a base tick (default 1 ms at 40 MHz) from the system clock.
- The base tick drives N_CH independent countdown channels. Each channel is started with a tick count, runs one-shot or periodic, and pulses on expiry.
- Used by game logic for jump timing, animation steps and countdowns.

---
 rtl/multi_channel_tick_timer.sv | 105 ++++++++++
 tb/tb_multi_channel_tick_timer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_tick_timer.sv
//------------------------------------------------------------------------------
// Module      : multi_channel_tick_timer
// Description : Shared prescaler producing a base tick, driving N_CH independent
//               one-shot/periodic countdown channels with expiry pulses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multi_channel_tick_timer #(
    parameter int CLK_HZ  = 40_000_000,
    parameter int TICK_HZ = 1000,
    parameter int N_CH    = 4,
    parameter int CNT_W   = 16
) (
    input  logic                    clk_40MHz,
    input  logic                    rst,
    output logic                    tick_ms,
    input  logic [N_CH-1:0]         ch_start,
    input  logic [N_CH-1:0]         ch_stop,
    input  logic [N_CH-1:0]         ch_periodic,
    input  logic [N_CH*CNT_W-1:0]   ch_load,
    output logic [N_CH-1:0]         ch_busy,
    output logic [N_CH-1:0]         ch_expired,
    output logic [N_CH*CNT_W-1:0]   ch_count
);

    localparam int              PRESCALE = CLK_HZ / TICK_HZ;
    localparam int              PS_W     = $clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [PS_W-1:0] r_prescale;

    // Free-running prescaler; channel activity never disturbs it.
    always_ff @(posedge clk_40MHz) begin
        if (rst) begin
            r_prescale <= '0;
            tick_ms    <= 1'b0;
        end else if (r_prescale == PS_LAST) begin
            r_prescale <= '0;
            tick_ms    <= 1'b1;
        end else begin
            r_prescale <= r_prescale + 1'b1;
            tick_ms    <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_count;
        logic [CNT_W-1:0] r_load;
        logic             r_mode;
        logic             r_busy;
        logic             r_exp;
        logic [CNT_W-1:0] w_load;

        assign w_load = ch_load[i*CNT_W +: CNT_W];

        // Priority: start over stop over tick. A running channel always holds count >= 1.
        always_ff @(posedge clk_40MHz) begin
            if (rst) begin
                r_count <= '0;
                r_load  <= '0;
                r_mode  <= 1'b0;
                r_busy  <= 1'b0;
                r_exp   <= 1'b0;
            end else begin
                r_exp <= 1'b0;
                if (ch_start[i]) begin
                    r_load <= w_load;
                    r_mode <= ch_periodic[i];
                    if (w_load != '0) begin
                        r_busy  <= 1'b1;
                        r_count <= w_load;
                    end else begin
                        r_busy  <= 1'b0;
                        r_count <= '0;
                        r_exp   <= 1'b1;
                    end
                end else if (ch_stop[i]) begin
                    r_busy  <= 1'b0;
                    r_count <= '0;
                end else if (tick_ms && r_busy) begin
                    if (r_count == CNT_ONE) begin
                        r_exp <= 1'b1;
                        if (r_mode) begin
                            r_count <= r_load;
                        end else begin
                            r_busy  <= 1'b0;
                            r_count <= '0;
                        end
                    end else begin
                        r_count <= r_count - CNT_ONE;
                    end
                end
            end
        end

        assign ch_busy[i]                   = r_busy;
        assign ch_expired[i]                = r_exp;
        assign ch_count[i*CNT_W +: CNT_W]   = r_count;
    end

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_tick_timer.sv
//------------------------------------------------------------------------------
// Module      : tb_multi_channel_tick_timer
// Description : Directed self-checking bench for multi_channel_tick_timer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multi_channel_tick_timer;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;

    logic                  clk_40MHz = 1'b0;
    logic                  rst;
    logic                  tick_ms;
    logic [N_CH-1:0]       ch_start;
    logic [N_CH-1:0]       ch_stop;
    logic [N_CH-1:0]       ch_periodic;
    logic [N_CH*CNT_W-1:0] ch_load;
    logic [N_CH-1:0]       ch_busy;
    logic [N_CH-1:0]       ch_expired;
    logic [N_CH*CNT_W-1:0] ch_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int pulses [N_CH];
    logic busy3_seen;
    int start_cyc;
    int elapsed;

    multi_channel_tick_timer #(
        .CLK_HZ (40),
        .TICK_HZ(4),
        .N_CH   (N_CH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_40MHz  (clk_40MHz),
        .rst        (rst),
        .tick_ms    (tick_ms),
        .ch_start   (ch_start),
        .ch_stop    (ch_stop),
        .ch_periodic(ch_periodic),
        .ch_load    (ch_load),
        .ch_busy    (ch_busy),
        .ch_expired (ch_expired),
        .ch_count   (ch_count)
    );

    always #5 clk_40MHz = ~clk_40MHz;

    task automatic step();
        @(posedge clk_40MHz);
        #1;
        cyc++;
        for (int i = 0; i < N_CH; i++) pulses[i] += int'(ch_expired[i]);
        if (ch_busy[3]) busy3_seen = 1'b1;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int ch);
        return 32'(ch_count[ch*CNT_W +: CNT_W]);
    endfunction

    task automatic set_load(input int ch, input logic [CNT_W-1:0] val);
        ch_load[ch*CNT_W +: CNT_W] = val;
    endtask

    task automatic clear_pulses();
        for (int i = 0; i < N_CH; i++) pulses[i] = 0;
    endtask

    initial begin
        rst = 1'b1; ch_start = '0; ch_stop = '0; ch_periodic = '0; ch_load = '0;
        busy3_seen = 1'b0;
        clear_pulses();
        repeat (3) step();
        chk("reset_tick", 32'(tick_ms), 0);
        chk("reset_outputs", 32'({ch_busy, ch_expired} | 8'(|ch_count)), 0);

        // Prescaler alone: tick on cycles 10, 20, 30 after release
        rst = 1'b0; cyc = 0;
        for (int n = 1; n <= 35; n++) begin
            step();
            chk($sformatf("tick_c%0d", n), 32'(tick_ms), 32'(n % 10 == 0));
            chk($sformatf("idle_c%0d", n), 32'({ch_busy, ch_expired} | 8'(|ch_count)), 0);
        end

        // One-shot ch0, L=3, started the cycle after tick_ms
        step_to(41);
        ch_start[0] = 1'b1; set_load(0, 8'd3); ch_periodic[0] = 1'b0;
        step(); ch_start[0] = 1'b0; clear_pulses();
        chk("os_busy_start", 32'(ch_busy[0]), 1);
        chk("os_count_start", cnt(0), 3);
        step_to(51); chk("os_count_t1", cnt(0), 2);
        step_to(61); chk("os_count_t2", cnt(0), 1);
        step_to(70); chk("os_no_early_exp", 32'(ch_expired[0]), 0);
        step_to(71);
        chk("os_exp", 32'(ch_expired[0]), 1);
        chk("os_busy_end", 32'(ch_busy[0]), 0);
        chk("os_count_end", cnt(0), 0);
        step_to(121); chk("os_pulse_total", 32'(pulses[0]), 1);

        // Periodic ch1, L=2: pulses at 141, 161, 181, 201
        ch_start[1] = 1'b1; set_load(1, 8'd2); ch_periodic[1] = 1'b1;
        step(); ch_start[1] = 1'b0; clear_pulses();
        chk("per_count_start", cnt(1), 2);
        step_to(131); chk("per_count_t1", cnt(1), 1);
        step_to(141);
        chk("per_exp1", 32'(ch_expired[1]), 1);
        chk("per_reload", cnt(1), 2);
        chk("per_busy", 32'(ch_busy[1]), 1);
        step_to(201);
        chk("per_exp4", 32'(ch_expired[1]), 1);
        chk("per_pulses", 32'(pulses[1]), 4);
        ch_stop[1] = 1'b1;
        step(); ch_stop[1] = 1'b0; clear_pulses();
        chk("per_stop", 32'({ch_busy[1], ch_count[CNT_W +: CNT_W]}), 0);
        step_to(250); chk("per_after_stop", 32'(pulses[1]), 0);

        // ch2 start coinciding with tick: count holds at L
        chk("col_tick_present", 32'(tick_ms), 1);
        ch_start[2] = 1'b1; set_load(2, 8'd5); ch_periodic[2] = 1'b0;
        step(); ch_start[2] = 1'b0;
        chk("col_start_on_tick", cnt(2), 5);
        step_to(261); chk("col_count_t1", cnt(2), 4);
        step_to(271); chk("col_count_t2", cnt(2), 3);
        // Restart with L=1 while count=3
        ch_start[2] = 1'b1; set_load(2, 8'd1);
        step(); ch_start[2] = 1'b0;
        chk("col_restart", cnt(2), 1);
        step_to(281);
        chk("col_restart_exp", 32'(ch_expired[2]), 1);
        chk("col_restart_busy", 32'(ch_busy[2]), 0);
        // Stop on the final tick suppresses expiry
        ch_start[2] = 1'b1; set_load(2, 8'd2);
        step(); ch_start[2] = 1'b0; clear_pulses();
        step_to(291); chk("col_stop_pre", cnt(2), 1);
        step_to(300); ch_stop[2] = 1'b1;
        step(); ch_stop[2] = 1'b0;
        chk("col_stop_final", 32'({ch_busy[2], ch_expired[2], ch_count[2*CNT_W +: CNT_W]}), 0);
        step_to(320); chk("col_stop_pulses", 32'(pulses[2]), 0);

        // ch3 L=0: immediate expiry, never busy
        busy3_seen = 1'b0;
        ch_start[3] = 1'b1; set_load(3, 8'd0); ch_periodic[3] = 1'b0;
        step(); ch_start[3] = 1'b0;
        chk("zero_exp", 32'(ch_expired[3]), 1);
        step();
        chk("zero_exp_once", 32'(ch_expired[3]), 0);
        chk("zero_never_busy", 32'(busy3_seen), 0);

        // ch3 L=255 periodic: no wrap, first expiry within 2541..2550 cycles
        ch_start[3] = 1'b1; set_load(3, 8'd255); ch_periodic[3] = 1'b1;
        step(); ch_start[3] = 1'b0;
        start_cyc = cyc;
        chk("max_count_start", cnt(3), 255);
        step_to(331); chk("max_count_t1", cnt(3), 254);
        while (!ch_expired[3] && (cyc - start_cyc) < 2600) step();
        elapsed = cyc - start_cyc;
        chk("max_exp_seen", 32'(ch_expired[3]), 1);
        chk("max_exp_window", 32'(elapsed >= 2541 && elapsed <= 2550), 1);
        chk("max_exp_cycle", 32'(cyc), 2871);
        chk("max_reload", cnt(3), 255);

        // All channels busy, then reset aborts everything silently
        ch_start = 4'b0111; ch_load[3*CNT_W-1:0] = {8'd10, 8'd10, 8'd10}; ch_periodic = '0;
        step(); ch_start = '0;
        chk("all_busy", 32'(ch_busy), 32'hF);
        rst = 1'b1;
        step();
        chk("rst_mid_busy", 32'(ch_busy), 0);
        chk("rst_mid_exp", 32'(ch_expired), 0);
        chk("rst_mid_count", 32'(|ch_count), 0);
        chk("rst_mid_tick", 32'(tick_ms), 0);
        rst = 1'b0; cyc = 0;
        for (int n = 1; n <= 10; n++) begin
            step();
            chk($sformatf("rst_tick_c%0d", n), 32'(tick_ms), 32'(n == 10));
            chk($sformatf("rst_noexp_c%0d", n), 32'(ch_expired), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
